// File: rtl/uart_frame_assembler_if.sv
// Byte-receiver / command-processor bus for uart_frame_assembler.
// rx_valid is a one-cycle strobe with no back-pressure; RX_interrupt is a level held until RX_interrupt_clear is sampled while a frame is pending.
interface uart_frame_assembler_if #(
  parameter int uart_data_depth = 12
);
  logic                         rx_valid;
  logic [7:0]                   rx_data;
  logic                         rx_error;
  logic                         RX_interrupt_clear;
  logic [uart_data_depth*8-1:0] receive_data;
  logic                         RX_interrupt;
  logic [5:0]                   receive_data_bytes;
  logic                         frame_overflow;
  logic                         frame_dropped;

  modport master (
    output rx_valid, rx_data, rx_error, RX_interrupt_clear,
    input  receive_data, RX_interrupt, receive_data_bytes, frame_overflow, frame_dropped
  );

  modport slave (
    input  rx_valid, rx_data, rx_error, RX_interrupt_clear,
    output receive_data, RX_interrupt, receive_data_bytes, frame_overflow, frame_dropped
  );
endinterface

// File: rtl/uart_frame_assembler.sv
// Sliding-window frame assembler: shifts received bytes in until CR LF, then holds the frame for the processor.
// Optional inter-byte timeout is enabled by defining FRAME_TIMEOUT_EN.
module uart_frame_assembler #(
  parameter int uart_data_depth = 12,
  parameter int TIMEOUT_CYCLES  = 100000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  uart_frame_assembler_if.slave  bus,
  output logic [1:0]             o_dbg_state
);
  localparam int         W       = uart_data_depth * 8;
  localparam logic [5:0] DEPTH_C = 6'(uart_data_depth);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_HOLD    = 2'd2
  } state_t;

  state_t         r_state, w_state_nx;
  logic [W-1:0]   r_data, w_data_nx;
  logic [5:0]     r_count, w_count_nx;
  logic           r_ovf, w_ovf_nx;
  logic           r_int, w_int_nx;
  logic           r_drop, w_drop_nx;
  logic           w_byte, w_err, w_term, w_expire;

  assign w_byte = bus.rx_valid && !bus.rx_error;
  assign w_err  = bus.rx_valid && bus.rx_error;
  assign w_term = (bus.rx_data == 8'h0A) && (r_data[7:0] == 8'h0D) && (r_count != 6'd0);

`ifdef FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] r_tmo, w_tmo_nx;

  assign w_expire = (r_state == S_COLLECT) && (r_tmo == TW'(TIMEOUT_CYCLES - 1));

  // Counts idle cycles only while a partial frame stays in COLLECT.
  always_comb begin
    w_tmo_nx = '0;
    if (r_state == S_COLLECT && w_state_nx == S_COLLECT && !w_byte)
      w_tmo_nx = r_tmo + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_tmo <= '0;
    else        r_tmo <= w_tmo_nx;
  end
`else
  assign w_expire = 1'b0;
`endif

  always_comb begin
    w_state_nx = r_state;
    w_data_nx  = r_data;
    w_count_nx = r_count;
    w_ovf_nx   = r_ovf;
    w_int_nx   = r_int;
    w_drop_nx  = 1'b0;
    case (r_state)
      S_IDLE, S_COLLECT: begin
        if (w_err) begin
          w_data_nx  = '0;
          w_count_nx = '0;
          w_ovf_nx   = 1'b0;
          w_state_nx = S_IDLE;
          w_drop_nx  = (r_count != 6'd0);
        end else if (w_byte) begin
          w_data_nx  = {r_data[W-9:0], bus.rx_data};
          w_count_nx = (r_count == DEPTH_C) ? r_count : r_count + 6'd1;
          if (r_count == DEPTH_C) w_ovf_nx = 1'b1;
          w_state_nx = w_term ? S_HOLD : S_COLLECT;
          w_int_nx   = w_term;
        end else if (w_expire) begin
          w_data_nx  = '0;
          w_count_nx = '0;
          w_ovf_nx   = 1'b0;
          w_state_nx = S_IDLE;
          w_drop_nx  = 1'b1;
        end
      end
      S_HOLD: begin
        // A clear outranks a byte in the same cycle; that byte opens the next frame.
        if (bus.RX_interrupt_clear) begin
          w_int_nx = 1'b0;
          w_ovf_nx = 1'b0;
          if (w_byte) begin
            w_data_nx  = W'(bus.rx_data);
            w_count_nx = 6'd1;
            w_state_nx = S_COLLECT;
          end else begin
            w_data_nx  = '0;
            w_count_nx = '0;
            w_state_nx = S_IDLE;
          end
        end else if (bus.rx_valid) begin
          w_drop_nx = 1'b1;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_data  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_int   <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_data  <= w_data_nx;
      r_count <= w_count_nx;
      r_ovf   <= w_ovf_nx;
      r_int   <= w_int_nx;
      r_drop  <= w_drop_nx;
    end
  end

  assign bus.receive_data       = r_data;
  assign bus.RX_interrupt       = r_int;
  assign bus.receive_data_bytes = r_count;
  assign bus.frame_overflow     = r_ovf;
  assign bus.frame_dropped      = r_drop;
  assign o_dbg_state            = r_state;
endmodule

// File: tb/tb_uart_frame_assembler.sv
// Bench for uart_frame_assembler: directed scenarios plus random traffic, checked against a byte-list frame model.
module tb_uart_frame_assembler;
  localparam int DEPTH = 12;
  localparam int W     = DEPTH * 8;
  localparam int FW    = W + 7;
`ifdef FRAME_TIMEOUT_EN
  localparam int TMO = 50;
`else
  localparam int TMO = 100000;
`endif

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  int         cyc;
  int         total;
  int         bad;

  uart_frame_assembler_if #(.uart_data_depth(DEPTH)) bus ();

  uart_frame_assembler #(.uart_data_depth(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // reference model: the current frame as a plain byte list
  logic [7:0]    m_frame[$];
  bit            m_hold;
  int            m_idle;
  logic [FW-1:0] exp_q[$];
  int            exp_cyc_q[$];
  int            drop_cyc_q[$];

  function automatic logic [FW-1:0] model_window();
    logic [W-1:0] win;
    int n;
    int keep;
    win  = '0;
    n    = m_frame.size();
    keep = (n > DEPTH) ? DEPTH : n;
    for (int k = 0; k < keep; k++) win[8*k +: 8] = m_frame[n-1-k];
    return {win, 6'(keep), (n > DEPTH)};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h cyc=%0d", name, act, req, cyc);
    end
  endtask

  // driver: one clock of inputs, model updated for the same cycle
  task automatic step(input bit v, input logic [7:0] b, input bit e, input bit c);
    int n;
    if (m_hold) begin
      if (c) begin
        m_hold = 0;
        m_frame.delete();
        m_idle = 0;
        if (v && !e) m_frame.push_back(b);
      end else if (v) begin
        drop_cyc_q.push_back(cyc + 1);
      end
    end else if (v && e) begin
      if (m_frame.size() > 0) drop_cyc_q.push_back(cyc + 1);
      m_frame.delete();
      m_idle = 0;
    end else if (v) begin
      m_frame.push_back(b);
      m_idle = 0;
      n = m_frame.size();
      if (n >= 2 && m_frame[n-1] == 8'h0A && m_frame[n-2] == 8'h0D) begin
        exp_q.push_back(model_window());
        exp_cyc_q.push_back(cyc + 1);
        m_hold = 1;
      end
    end else if (m_frame.size() > 0) begin
`ifdef FRAME_TIMEOUT_EN
      m_idle++;
      if (m_idle == TMO) begin
        drop_cyc_q.push_back(cyc + 1);
        m_frame.delete();
        m_idle = 0;
      end
`endif
    end
    bus.rx_valid           = v;
    bus.rx_data            = b;
    bus.rx_error           = e;
    bus.RX_interrupt_clear = c;
    @(posedge clk);
    #1;
    bus.rx_valid           = 1'b0;
    bus.rx_error           = 1'b0;
    bus.RX_interrupt_clear = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    step(1, b, 0, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 0, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    m_frame.delete();
    m_hold = 0;
    m_idle = 0;
  endtask

  // monitor / scoreboard
  initial begin : monitor
    logic          prev_int;
    logic [FW-1:0] held;
    logic [FW-1:0] got;
    logic [FW-1:0] e;
    int            ec;
    prev_int = 1'b0;
    held     = '0;
    forever begin
      @(negedge clk);
      got = {bus.receive_data, bus.receive_data_bytes, bus.frame_overflow};
      if (rst_n) begin
        if (bus.RX_interrupt && !prev_int) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_frame actual=%h required=none cyc=%0d", got, cyc);
          end else begin
            e  = exp_q.pop_front();
            ec = exp_cyc_q.pop_front();
            if (got !== e || cyc != ec) begin
              bad++;
              $display("FAIL frame actual=%h@%0d required=%h@%0d", got, cyc, e, ec);
            end
          end
          held = got;
        end else if (bus.RX_interrupt && prev_int) begin
          total++;
          if (got !== held) begin
            bad++;
            $display("FAIL hold_stable actual=%h required=%h cyc=%0d", got, held, cyc);
          end
        end
        if (bus.frame_dropped) begin
          total++;
          if (drop_cyc_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_drop actual=1 required=0 cyc=%0d", cyc);
          end else begin
            ec = drop_cyc_q.pop_front();
            if (cyc != ec) begin
              bad++;
              $display("FAIL drop_time actual=%0d required=%0d", cyc, ec);
            end
          end
        end
      end
      prev_int = bus.RX_interrupt;
    end
  end

  logic [7:0] normal_frame [0:10] = '{8'h55, 8'h5D, 8'h01, 8'h12, 8'h34, 8'h00,
                                      8'h00, 8'h00, 8'h00, 8'h0D, 8'h0A};

  initial begin : stimulus
    logic [7:0] rb;
    int         r;
    total = 0;
    bad   = 0;
    m_hold = 0;
    m_idle = 0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rx_error = 1'b0;
    bus.RX_interrupt_clear = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data",  bus.receive_data, 0);
    check("rst_int",   bus.RX_interrupt, 0);
    check("rst_bytes", bus.receive_data_bytes, 0);
    check("rst_ovf",   bus.frame_overflow, 0);
    check("rst_drop",  bus.frame_dropped, 0);
    check("rst_state_idle", dbg_state, 2'd0);
    rst_n = 1'b1;
    idle(2);

    // normal frame
    for (int i = 0; i < 11; i++) send(normal_frame[i]);
    check("nf_int",      bus.RX_interrupt, 1);
    check("nf_hdr",      bus.receive_data[87:80], 8'h55);
    check("nf_b8",       bus.receive_data[71:64], 8'h01);
    check("nf_tail",     bus.receive_data[15:0], 16'h0D0A);
    check("nf_bytes",    bus.receive_data_bytes, 11);
    check("nf_ovf",      bus.frame_overflow, 0);
    idle(3);
    step(0, 8'h00, 0, 1);
    check("clr_int",   bus.RX_interrupt, 0);
    check("clr_data",  bus.receive_data, 0);
    check("clr_bytes", bus.receive_data_bytes, 0);
    step(0, 8'h00, 0, 1);
    step(0, 8'h00, 0, 1);
    check("clr_held_idle", bus.receive_data_bytes, 0);

    // frame after clear, then clear together with a byte
    send(8'hAA); send(8'h0D); send(8'h0A);
    check("f2_int", bus.RX_interrupt, 1);
    step(1, 8'h55, 0, 1);
    check("cwb_int",   bus.RX_interrupt, 0);
    check("cwb_data",  bus.receive_data, 8'h55);
    check("cwb_bytes", bus.receive_data_bytes, 1);
    check("cwb_drop",  bus.frame_dropped, 0);
    send(8'h0D); send(8'h0A);
    check("cwb_frame_bytes", bus.receive_data_bytes, 3);
    step(0, 8'h00, 0, 1);

    // over-long frame: 13 payload bytes + CR LF
    for (int i = 0; i < 13; i++) send(8'(8'h20 + i));
    send(8'h0D); send(8'h0A);
    check("ol_bytes",  bus.receive_data_bytes, 12);
    check("ol_ovf",    bus.frame_overflow, 1);
    check("ol_oldest", bus.receive_data[95:88], 8'h23);
    send(8'h77);
    check("ol_drop",   bus.frame_dropped, 1);
    check("ol_keep",   bus.receive_data[15:0], 16'h0D0A);
    step(0, 8'h00, 0, 1);
    check("ol_ovf_clr", bus.frame_overflow, 0);

    // line error mid-frame, then in idle, then a lone LF
    send(8'h55); send(8'h5D);
    step(1, 8'hFF, 1, 0);
    check("le_drop",  bus.frame_dropped, 1);
    check("le_data",  bus.receive_data, 0);
    check("le_bytes", bus.receive_data_bytes, 0);
    step(1, 8'h00, 1, 0);
    check("le_idle_nodrop", bus.frame_dropped, 0);
    send(8'h0A);
    check("lone_lf_int", bus.RX_interrupt, 0);
    send(8'h0D); send(8'h0A);
    check("le_recover_int", bus.RX_interrupt, 1);
    step(0, 8'h00, 0, 1);

    // inter-byte timeout
    send(8'h55); send(8'h5D);
    idle(50);
`ifdef FRAME_TIMEOUT_EN
    check("tmo_data",  bus.receive_data, 0);
    check("tmo_bytes", bus.receive_data_bytes, 0);
`else
    check("notmo_bytes", bus.receive_data_bytes, 2);
`endif
    send(8'h0D); send(8'h0A);
    check("tmo_after_int", bus.RX_interrupt, 1);
    step(0, 8'h00, 0, 1);
    send(8'h31);
    idle(TMO > 60 ? 49 : TMO - 1);
    send(8'h0D); send(8'h0A);
    check("tmo_edge_bytes", bus.receive_data_bytes, 3);
    step(0, 8'h00, 0, 1);

    // reset mid-frame and in HOLD
    send(8'h11); send(8'h22);
    idle(2);
    do_reset();
    check("rmid_bytes", bus.receive_data_bytes, 0);
    check("rmid_data",  bus.receive_data, 0);
    send(8'h0D); send(8'h0A);
    idle(2);
    do_reset();
    check("rhold_int", bus.RX_interrupt, 0);
    check("rhold_bytes", bus.receive_data_bytes, 0);

    // random traffic
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 99);
      if (m_hold) begin
        if (r < 30)      step(0, 8'h00, 0, 1);
        else if (r < 40) step(1, 8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0), 1);
        else if (r < 55) step(1, 8'($urandom_range(0, 255)), 0, 0);
        else             step(0, 8'h00, 0, 0);
      end else begin
        if (r < 4)       rb = 8'($urandom_range(0, 255));
        else if (r < 20) rb = 8'h0D;
        else if (r < 35) rb = 8'h0A;
        else             rb = 8'($urandom_range(0, 255));
        if (r >= 90)     idle($urandom_range(1, 3));
        else             step(1, rb, (r < 4), ($urandom_range(0, 9) == 0));
      end
    end
    if (m_hold) step(0, 8'h00, 0, 1);
    idle(5);

    check("exp_frames_left", exp_q.size(), 0);
    check("exp_drops_left",  drop_cyc_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
